sd_cmd_engine: RTL and testbench

- SPI-mode SD command engine directly downstream of sd_interface's control FSM; sd_interface drives it to issue one SD command.
- Frames a 48-bit command (start bits, index, argument, CRC7, end bit) and shifts it out on SDDI.
- Polls the card with 0xFF bytes until an R1 response arrives on SDDO or the poll limit expires.
- Returns R1 or a timeout flag; owns the SDCLK/SDDI/SDCS pins during a command.

---
 rtl/sd_pkg.sv | 22 ++
 rtl/sd_spi_byte.sv | 70 +++++++
 rtl/sd_cmd_engine.sv | 170 +++++++++++++++++
 tb/tb_sd_cmd_engine.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
// Shared types, constants and CRC7 helper for the SPI-mode SD command engine.
package sd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    POLL = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int          CMD_FRAME_BYTES = 6;
  localparam logic [7:0]  SD_IDLE_BYTE    = 8'hFF;
  localparam logic [6:0]  CRC7_POLY       = 7'h09;

  // One serial step of CRC7 (x^7 + x^3 + 1), data fed MSB first.
  function automatic logic [6:0] crc7_update(input logic [6:0] crc, input logic din);
    logic fb;
    fb = crc[6] ^ din;
    return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/sd_spi_byte.sv
// SPI mode-0 byte shifter: generates SDCLK, shifts tx MSB first on the low
// phase and samples miso in the cycle SDCLK rises. 'done' is a combinational
// pulse in the last clk cycle of the final high phase, so a 'start' seen in
// that same cycle chains the next byte with no idle gap.
module sd_spi_byte #(
  parameter int CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       start,
  input  logic [7:0] tx_byte,
  output logic [7:0] rx_byte,
  output logic       done,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic             active;
  logic [DIV_W-1:0] div_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       tx_sh;
  logic [7:0]       rx_sh;
  logic             half_end;

  assign half_end = active && (div_cnt == DIV_W'(CLK_DIV - 1));
  assign done     = half_end && sclk && (bit_cnt == 3'd7);
  assign rx_byte  = rx_sh;

  // Half-period counter, SDCLK toggling, bit shifting and SDDO capture.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      active  <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= 3'd0;
      tx_sh   <= 8'hFF;
      rx_sh   <= 8'hFF;
      sclk    <= 1'b0;
      mosi    <= 1'b1;
    end else if (start && (!active || done)) begin
      active  <= 1'b1;
      div_cnt <= '0;
      bit_cnt <= 3'd0;
      tx_sh   <= tx_byte;
      mosi    <= tx_byte[7];
      sclk    <= 1'b0;
    end else if (half_end) begin
      div_cnt <= '0;
      if (!sclk) begin
        sclk  <= 1'b1;
        rx_sh <= {rx_sh[6:0], miso};
      end else begin
        sclk <= 1'b0;
        if (bit_cnt == 3'd7) begin
          active <= 1'b0;
          mosi   <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 3'd1;
          tx_sh   <= {tx_sh[6:0], 1'b0};
          mosi    <= tx_sh[6];
        end
      end
    end else if (active) begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/sd_cmd_engine.sv
// SPI-mode SD command engine: frames a 48-bit command with CRC7, polls the
// card with 0xFF bytes for an R1 response, and reports R1 or a timeout.
//
// Handshake: cmd_start is a one-cycle request honoured only in IDLE while
// cmd_done is low; cmd_busy rises the cycle after acceptance and falls in
// the cycle cmd_done pulses. Requests at any other time are dropped.
module sd_cmd_engine
  import sd_pkg::*;
#(
  parameter int CLK_DIV        = 2,
  parameter int RESP_MAX_BYTES = 8
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        cmd_start,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  input  logic        cs_hold,
  output logic        cmd_busy,
  output logic        cmd_done,
  output logic [7:0]  resp_r1,
  output logic        resp_timeout,
  output logic        SDCS,
  output logic        SDCLK,
  output logic        SDDI,
  input  logic        SDDO,
  output logic [1:0]  dbg_state
);

  state_t      state;
  logic [2:0]  byte_idx;
  logic [7:0]  poll_cnt;
  logic [31:0] arg_q;
  logic [6:0]  crc_q;
  logic        hold_q;
  logic        to_pend;

  logic        accept;
  logic [2:0]  nxt_idx;
  logic [39:0] frame40;
  logic [6:0]  crc_in;
  logic [7:0]  send_next;
  logic [7:0]  spi_tx;
  logic [7:0]  spi_rx;
  logic        spi_start;
  logic        spi_done;
  logic        poll_last;

  assign dbg_state = state;
  assign accept    = (state == IDLE) && cmd_start && !cmd_done;
  assign nxt_idx   = byte_idx + 3'd1;
  assign poll_last = (poll_cnt == 8'(RESP_MAX_BYTES - 1));

  // CRC7 over the first five frame bytes, taken straight from the request inputs.
  always_comb begin
    frame40 = {2'b01, cmd_index, cmd_arg};
    crc_in  = 7'h00;
    for (int i = 39; i >= 0; i--) begin
      crc_in = crc7_update(crc_in, frame40[i]);
    end
  end

  // Next byte to shift; index 6 rolls over into the first poll byte.
  always_comb begin
    send_next = SD_IDLE_BYTE;
    case (nxt_idx)
      3'd1:    send_next = arg_q[31:24];
      3'd2:    send_next = arg_q[23:16];
      3'd3:    send_next = arg_q[15:8];
      3'd4:    send_next = arg_q[7:0];
      3'd5:    send_next = {crc_q, 1'b1};
      default: send_next = SD_IDLE_BYTE;
    endcase
  end

  // Byte-shifter feed: launch on accept, then chain on each byte completion.
  always_comb begin
    spi_tx    = SD_IDLE_BYTE;
    spi_start = 1'b0;
    if (accept) begin
      spi_tx    = {2'b01, cmd_index};
      spi_start = 1'b1;
    end else if (spi_done && state == SEND) begin
      spi_tx    = send_next;
      spi_start = 1'b1;
    end else if (spi_done && state == POLL && spi_rx[7] && !poll_last) begin
      spi_tx    = SD_IDLE_BYTE;
      spi_start = 1'b1;
    end
  end

  sd_spi_byte #(.CLK_DIV(CLK_DIV)) u_spi (
    .clk     (clk),
    .n_rst   (n_rst),
    .start   (spi_start),
    .tx_byte (spi_tx),
    .rx_byte (spi_rx),
    .done    (spi_done),
    .sclk    (SDCLK),
    .mosi    (SDDI),
    .miso    (SDDO)
  );

  // Command sequencing FSM with registered status and chip-select outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= IDLE;
      byte_idx     <= 3'd0;
      poll_cnt     <= 8'd0;
      arg_q        <= 32'h0;
      crc_q        <= 7'h00;
      hold_q       <= 1'b0;
      to_pend      <= 1'b0;
      cmd_busy     <= 1'b0;
      cmd_done     <= 1'b0;
      resp_r1      <= 8'hFF;
      resp_timeout <= 1'b0;
      SDCS         <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          cmd_done <= 1'b0;
          if (accept) begin
            arg_q        <= cmd_arg;
            crc_q        <= crc_in;
            hold_q       <= cs_hold;
            resp_timeout <= 1'b0;
            SDCS         <= 1'b0;
            cmd_busy     <= 1'b1;
            byte_idx     <= 3'd0;
            state        <= SEND;
          end
        end
        SEND: begin
          if (spi_done) begin
            if (byte_idx == 3'(CMD_FRAME_BYTES - 1)) begin
              poll_cnt <= 8'd0;
              state    <= POLL;
            end else begin
              byte_idx <= nxt_idx;
            end
          end
        end
        POLL: begin
          if (spi_done) begin
            if (!spi_rx[7]) begin
              to_pend <= 1'b0;
              state   <= DONE;
            end else if (poll_last) begin
              to_pend <= 1'b1;
              state   <= DONE;
            end else begin
              poll_cnt <= poll_cnt + 8'd1;
            end
          end
        end
        DONE: begin
          cmd_done     <= 1'b1;
          cmd_busy     <= 1'b0;
          resp_r1      <= to_pend ? SD_IDLE_BYTE : spi_rx;
          resp_timeout <= to_pend;
          if (!hold_q) SDCS <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_cmd_engine.sv
// Directed bench for sd_cmd_engine with an SD card model on the SPI pins and
// a queue-based scoreboard checked on every cmd_done.
module tb_sd_cmd_engine;

  localparam int CLK_DIV        = 2;
  localparam int RESP_MAX_BYTES = 8;
  // {frame[47:0], r1[7:0], timeout, sdcs_after, nbytes[7:0]}
  localparam int W = 66;

  logic        clk;
  logic        n_rst;
  logic        cmd_start;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic        cs_hold;
  logic        cmd_busy;
  logic        cmd_done;
  logic [7:0]  resp_r1;
  logic        resp_timeout;
  logic        SDCS;
  logic        SDCLK;
  logic        SDDI;
  logic        SDDO;
  logic [1:0]  dbg_state;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  // card model state
  logic [7:0] mosi_bytes[$];
  logic [7:0] card_shift;
  int         edge_cnt;
  int         cyc_since;
  logic       prev_sclk;
  logic       period_bad;
  logic       cs_bad;
  int         card_delay;
  logic [7:0] card_byte;
  logic       done_prev;

  sd_cmd_engine #(.CLK_DIV(CLK_DIV), .RESP_MAX_BYTES(RESP_MAX_BYTES)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .cmd_start    (cmd_start),
    .cmd_index    (cmd_index),
    .cmd_arg      (cmd_arg),
    .cs_hold      (cs_hold),
    .cmd_busy     (cmd_busy),
    .cmd_done     (cmd_done),
    .resp_r1      (resp_r1),
    .resp_timeout (resp_timeout),
    .SDCS         (SDCS),
    .SDCLK        (SDCLK),
    .SDDI         (SDDI),
    .SDDO         (SDDO),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Card: captures SDDI on SDCLK rise, shifts its response out after falls.
  always @(negedge clk) begin : card_model
    int k;
    int p;
    int b;
    if (SDCLK && !prev_sclk) begin
      if (edge_cnt > 0 && cyc_since != 2 * CLK_DIV) period_bad = 1'b1;
      if (SDCS) cs_bad = 1'b1;
      cyc_since  = 0;
      card_shift = {card_shift[6:0], SDDI};
      edge_cnt++;
      if (edge_cnt % 8 == 0) mosi_bytes.push_back(card_shift);
    end
    if (!SDCLK && prev_sclk) begin
      k = edge_cnt;
      if (k >= 48) begin
        p = (k - 48) / 8;
        b = (k - 48) % 8;
        SDDO = (p == card_delay) ? card_byte[7 - b] : 1'b1;
      end
    end
    cyc_since++;
    prev_sclk = SDCLK;
  end

  // Scoreboard monitor: pops one expectation per cmd_done.
  always @(negedge clk) begin : monitor
    logic [W-1:0] e;
    logic [47:0]  fr;
    logic         polls_ok;
    if (n_rst && cmd_done) begin
      done_cnt++;
      check("done_pulse_prev_low", 64'(done_prev), 64'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_cmd_done actual=cmd_done required=no_cmd_done");
      end else begin
        e = exp_q.pop_front();
        fr = '0;
        polls_ok = 1'b1;
        for (int i = 0; i < mosi_bytes.size(); i++) begin
          if (i < 6) fr = {fr[39:0], mosi_bytes[i]};
          else if (mosi_bytes[i] !== 8'hFF) polls_ok = 1'b0;
        end
        check("frame",            64'(fr),                 64'(e[65:18]));
        check("resp_r1",          64'(resp_r1),            64'(e[17:10]));
        check("resp_timeout",     64'(resp_timeout),       64'(e[9]));
        check("sdcs_at_done",     64'(SDCS),               64'(e[8]));
        check("byte_count",       64'(mosi_bytes.size()),  64'(e[7:0]));
        check("poll_bytes_ff",    64'(polls_ok),           64'd1);
        check("sdclk_period",     64'(period_bad),         64'd0);
        check("sdcs_low_shifting",64'(cs_bad),             64'd0);
        check("busy_low_at_done", 64'(cmd_busy),           64'd0);
      end
    end
    done_prev = n_rst && cmd_done;
  end

  // driver tasks
  task automatic expect_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [7:0] crc_b,
                            input logic [7:0] r1, input logic to, input logic cs_after, input int nbytes);
    exp_q.push_back({2'b01, idx, arg, crc_b, r1, to, cs_after, 8'(nbytes)});
  endtask

  task automatic start_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic hold,
                           input int delay, input logic [7:0] rbyte);
    @(negedge clk);
    mosi_bytes.delete();
    edge_cnt   = 0;
    period_bad = 1'b0;
    cs_bad     = 1'b0;
    card_delay = delay;
    card_byte  = rbyte;
    SDDO       = 1'b1;
    cmd_index  = idx;
    cmd_arg    = arg;
    cs_hold    = hold;
    cmd_start  = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    check("busy_after_accept", 64'(cmd_busy), 64'd1);
  endtask

  task automatic wait_done(input string name);
    int  base;
    bit  seen;
    base = done_cnt;
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (done_cnt != base) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_done_wait actual=no_cmd_done required=cmd_done", name);
    end
  endtask

  task automatic wait_bytes(input int n);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      if (mosi_bytes.size() >= n) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL byte_wait actual=%0d required=%0d", mosi_bytes.size(), n);
    end
  endtask

  initial begin
    n_rst      = 1'b0;
    cmd_start  = 1'b0;
    cmd_index  = 6'd0;
    cmd_arg    = 32'h0;
    cs_hold    = 1'b0;
    SDDO       = 1'b1;
    edge_cnt   = 0;
    cyc_since  = 0;
    prev_sclk  = 1'b0;
    period_bad = 1'b0;
    cs_bad     = 1'b0;
    card_delay = 99;
    card_byte  = 8'hFF;
    card_shift = 8'hFF;
    done_prev  = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_busy",    64'(cmd_busy),     64'd0);
    check("rst_done",    64'(cmd_done),     64'd0);
    check("rst_r1",      64'(resp_r1),      64'hFF);
    check("rst_timeout", 64'(resp_timeout), 64'd0);
    check("rst_sdcs",    64'(SDCS),         64'd1);
    check("rst_sdclk",   64'(SDCLK),        64'd0);
    check("rst_sddi",    64'(SDDI),         64'd1);
    check("rst_state",   64'(dbg_state),    64'd0);
    n_rst = 1'b1;
    repeat (2) @(negedge clk);

    // CMD0: card answers 0x01 on the second poll byte -> 8 bytes, 64 SDCLK edges
    expect_cmd(6'd0, 32'h0, 8'h95, 8'h01, 1'b0, 1'b1, 8);
    start_cmd(6'd0, 32'h0, 1'b0, 1, 8'h01);
    wait_done("cmd0");

    // CMD8 with check pattern
    expect_cmd(6'd8, 32'h000001AA, 8'h87, 8'h01, 1'b0, 1'b1, 8);
    start_cmd(6'd8, 32'h000001AA, 1'b0, 1, 8'h01);
    wait_done("cmd8");

    // Card silent: exactly RESP_MAX_BYTES poll bytes then timeout
    expect_cmd(6'd0, 32'h0, 8'h95, 8'hFF, 1'b1, 1'b1, 6 + RESP_MAX_BYTES);
    start_cmd(6'd0, 32'h0, 1'b0, 99, 8'h00);
    wait_done("timeout");

    // Second request mid-SEND must be dropped without touching latched inputs
    expect_cmd(6'd8, 32'h000001AA, 8'h87, 8'h00, 1'b0, 1'b1, 7);
    start_cmd(6'd8, 32'h000001AA, 1'b0, 0, 8'h00);
    wait_bytes(2);
    @(negedge clk);
    cmd_index = 6'd17;
    cmd_arg   = 32'hDEADBEEF;
    cs_hold   = 1'b1;
    cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    check("busy_mid_send", 64'(cmd_busy), 64'd1);
    wait_done("ignored_start");

    // CMD17 with cs_hold: SDCS stays low after done
    expect_cmd(6'd17, 32'h0, 8'h55, 8'h00, 1'b0, 1'b0, 7);
    start_cmd(6'd17, 32'h0, 1'b1, 0, 8'h00);
    wait_done("cmd17_hold");
    repeat (10) @(negedge clk);
    check("sdcs_held_idle",  64'(SDCS),  64'd0);
    check("sdclk_idle_low",  64'(SDCLK), 64'd0);
    check("sddi_idle_high",  64'(SDDI),  64'd1);

    // Next command with cs_hold=0 releases SDCS at its cmd_done
    expect_cmd(6'd0, 32'h0, 8'h95, 8'h01, 1'b0, 1'b1, 7);
    start_cmd(6'd0, 32'h0, 1'b0, 0, 8'h01);
    wait_done("release");
    repeat (4) @(negedge clk);
    check("sdcs_released_idle", 64'(SDCS), 64'd1);

    // Reset during frame byte 3: immediate abort, no cmd_done
    start_cmd(6'd8, 32'h000001AA, 1'b0, 0, 8'h00);
    wait_bytes(3);
    repeat (3) @(posedge clk);
    #1 n_rst = 1'b0;
    #1;
    check("abort_sdcs",    64'(SDCS),         64'd1);
    check("abort_sdclk",   64'(SDCLK),        64'd0);
    check("abort_sddi",    64'(SDDI),         64'd1);
    check("abort_busy",    64'(cmd_busy),     64'd0);
    check("abort_done",    64'(cmd_done),     64'd0);
    check("abort_r1",      64'(resp_r1),      64'hFF);
    @(negedge clk);
    n_rst = 1'b1;
    repeat (60) @(negedge clk);

    // CMD0 after the abort frames cleanly
    expect_cmd(6'd0, 32'h0, 8'h95, 8'h01, 1'b0, 1'b1, 7);
    start_cmd(6'd0, 32'h0, 1'b0, 0, 8'h01);
    wait_done("cmd0_after_reset");

    repeat (5) @(negedge clk);
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    check("done_count",    64'(done_cnt),     64'd7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
